// File: rtl/mult_seq_pkg.sv
// Shared types and defaults for the multiplier sequencer and its wait timer.
package mult_seq_pkg;

    localparam int DEF_N           = 4;
    localparam int DEF_WAIT_CYCLES = 2 * DEF_N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/wait_timer.sv
// Down-counter that gives the external Multiplier its settling time.
module wait_timer #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Counts down to zero and parks there until the next load.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/mult_sequencer.sv
// Drives one job at a time through an external Multiplier: capture operands,
// pulse start, wait for settling, then hold the product until it is consumed.
module mult_sequencer
    import mult_seq_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int WAIT_CYCLES = 2 * N
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           start,
    output logic [N-1:0]   M,
    output logic [N-1:0]   Qin,
    input  logic [2*N-1:0] AQ,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*N-1:0] product,
    output logic [15:0]    job_count,
    output state_t         dbg_state_o
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

    state_t         state_q;
    logic           start_q;
    logic           res_valid_q;
    logic [N-1:0]   m_q;
    logic [N-1:0]   qin_q;
    logic [2*N-1:0] product_q;
    logic [15:0]    job_count_q;
    logic           timer_load;
    logic           timer_expired;

    // Timer is loaded during START so it reads WAIT_CYCLES-1 on the first WAIT cycle.
    assign timer_load = (state_q == START);

    wait_timer #(.W(CW)) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (timer_load),
        .value   (WAIT_LOAD),
        .expired (timer_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            m_q         <= '0;
            qin_q       <= '0;
            product_q   <= '0;
            job_count_q <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        m_q     <= a_in;
                        qin_q   <= b_in;
                        start_q <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (timer_expired) begin
                        product_q   <= AQ;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        job_count_q <= job_count_q + 16'd1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign start       = start_q;
    assign M           = m_q;
    assign Qin         = qin_q;
    assign res_valid   = res_valid_q;
    assign product     = product_q;
    assign job_count   = job_count_q;
    assign dbg_state_o = state_q;

endmodule
